ab_stim_player: RTL and testbench

Synthesizable stimulus/response engine for two-input, two-output sequential blocks under test. It plays a programmed table of (A, B) input vectors into the DUT one step at a time, holds each vector for a programmed number of cycles, and samples the DUT's X/Z outputs at the end of each step against expected values. It sits opposite the DUT in on-board lab builds, where a simulation bench cannot drive the DUT, and reports pass/fail plus the first failing step.

---
 rtl/stim_pkg.sv | 25 ++
 rtl/stim_vec_ram.sv | 22 ++
 rtl/ab_stim_player.sv | 141 ++++++++++++++
 tb/tb_ab_stim_player.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared types and table-entry layout for the A/B stimulus player.
package stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // An entry is {check, expZ, expX, B, A, hold}; flag offsets count up from the hold field.
  localparam int HOLD_LSB    = 0;
  localparam int A_BIT       = 0;
  localparam int B_BIT       = 1;
  localparam int EXPX_BIT    = 2;
  localparam int EXPZ_BIT    = 3;
  localparam int CHECK_BIT   = 4;
  localparam int ENTRY_FLAGS = 5;

  localparam logic [3:0] ERR_CNT_MAX = 4'd15;

  function automatic int entry_width(input int hold_w);
    return hold_w + ENTRY_FLAGS;
  endfunction

endpackage

// File: rtl/stim_vec_ram.sv
// Vector table: synchronous write, asynchronous read.
module stim_vec_ram #(
  parameter int NUM_STEPS = 8,
  parameter int WIDTH     = 9
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(NUM_STEPS)-1:0] waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [$clog2(NUM_STEPS)-1:0] raddr,
  output logic [WIDTH-1:0]             rdata
);

  logic [WIDTH-1:0] mem [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ab_stim_player.sv
// Plays a programmed (A, B) vector table into a DUT and checks its X/Z outputs per step.
// Optional STIM_LOOP_EN: keep replaying the table while start stays high at end of a pass.
module ab_stim_player
  import stim_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int HOLD_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
  input  logic [HOLD_W+4:0]            cfg_data,
  input  logic                         start,
  output logic                         A,
  output logic                         B,
  input  logic                         X,
  input  logic                         Z,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(NUM_STEPS)-1:0] err_step,
  output logic [3:0]                   err_count
);

  localparam int AW = $clog2(NUM_STEPS);
  localparam int EW = entry_width(HOLD_W);
  localparam int FB = HOLD_W;
  localparam logic [AW-1:0] LAST_STEP = AW'(NUM_STEPS - 1);

  state_t            state_reg, state_next;
  logic [AW-1:0]     step_reg, step_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [EW-1:0]     entry_reg, entry_next;
  logic [3:0]        err_count_reg, err_count_next;
  logic [AW-1:0]     err_step_reg, err_step_next;

  logic              ram_we;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     rd_data;
  logic [HOLD_W-1:0] hold_val, hold_last;
  logic              last_step, sample, mismatch;

  // Writes only land while idle, so the table is frozen for the duration of a run.
  assign ram_we = cfg_we && (state_reg == IDLE);

  stim_vec_ram #(
    .NUM_STEPS(NUM_STEPS),
    .WIDTH    (EW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // The current entry is latched into entry_reg, so one read port serves the next load.
  assign hold_val  = entry_reg[HOLD_LSB +: HOLD_W];
  assign hold_last = (hold_val == '0) ? '0 : hold_val - HOLD_W'(1);
  assign last_step = (step_reg == LAST_STEP);
  assign sample    = (state_reg == DRIVE) && (hold_cnt_reg == hold_last);
  assign mismatch  = entry_reg[FB+CHECK_BIT] &&
                     ({X, Z} != {entry_reg[FB+EXPX_BIT], entry_reg[FB+EXPZ_BIT]});
  assign rd_addr   = (state_reg == DRIVE && !last_step) ? step_reg + AW'(1) : '0;

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    hold_cnt_next  = hold_cnt_reg;
    entry_next     = entry_reg;
    err_count_next = err_count_reg;
    err_step_next  = err_step_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next     = DRIVE;
          step_next      = '0;
          hold_cnt_next  = '0;
          entry_next     = rd_data;
          err_count_next = '0;
          err_step_next  = '0;
        end
      end
      DRIVE: begin
        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        if (sample) begin
          if (mismatch) begin
            if (err_count_reg != ERR_CNT_MAX) err_count_next = err_count_reg + 4'd1;
            if (err_count_reg == '0) err_step_next = step_reg;
          end
          hold_cnt_next = '0;
          if (!last_step) begin
            step_next  = step_reg + AW'(1);
            entry_next = rd_data;
          end else begin
`ifdef STIM_LOOP_EN
            if (start) begin
              step_next  = '0;
              entry_next = rd_data;
            end else begin
              state_next = DONE;
            end
`else
            state_next = DONE;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      hold_cnt_reg  <= '0;
      entry_reg     <= '0;
      err_count_reg <= '0;
      err_step_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      hold_cnt_reg  <= hold_cnt_next;
      entry_reg     <= entry_next;
      err_count_reg <= err_count_next;
      err_step_reg  <= err_step_next;
    end
  end

  assign A         = entry_reg[FB+A_BIT];
  assign B         = entry_reg[FB+B_BIT];
  assign busy      = (state_reg == DRIVE);
  assign done      = (state_reg == DONE);
  assign pass      = (state_reg == DONE) && (err_count_reg == '0);
  assign err_step  = err_step_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_ab_stim_player.sv
// Scoreboard bench for ab_stim_player: an 8-step and a 16-step instance driving pass-through DUT models.
module tb_ab_stim_player;

  typedef struct {
    bit pass;
    int cnt;
    int step;
    int len;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 8-step instance
  logic       rst8 = 1'b1, we8 = 1'b0, start8 = 1'b0;
  logic [2:0] addr8 = '0;
  logic [8:0] data8 = '0;
  logic       A8, B8, X8, Z8, busy8, done8, pass8;
  logic [2:0] err_step8;
  logic [3:0] err_count8;

  // 16-step instance
  logic       rst16 = 1'b1, we16 = 1'b0, start16 = 1'b0;
  logic [3:0] addr16 = '0;
  logic [8:0] data16 = '0;
  logic       A16, B16, X16, Z16, busy16, done16, pass16;
  logic [3:0] err_step16;
  logic [3:0] err_count16;

  // Pass-through DUTs under test
  assign X8  = A8;
  assign Z8  = B8;
  assign X16 = A16;
  assign Z16 = B16;

  ab_stim_player #(.NUM_STEPS(8), .HOLD_W(4)) dut8 (
    .clk(clk), .rst(rst8), .cfg_we(we8), .cfg_addr(addr8), .cfg_data(data8),
    .start(start8), .A(A8), .B(B8), .X(X8), .Z(Z8), .busy(busy8), .done(done8),
    .pass(pass8), .err_step(err_step8), .err_count(err_count8)
  );

  ab_stim_player #(.NUM_STEPS(16), .HOLD_W(4)) dut16 (
    .clk(clk), .rst(rst16), .cfg_we(we16), .cfg_addr(addr16), .cfg_data(data16),
    .start(start16), .A(A16), .B(B16), .X(X16), .Z(Z16), .busy(busy16), .done(done16),
    .pass(pass16), .err_step(err_step16), .err_count(err_count16)
  );

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // {A,B} pattern for entry i; consecutive entries always differ
  function automatic int abv(input int i);
    return (i + 2) & 3;
  endfunction

  // Entry {check, expZ, expX, B, A, hold}; bad_x flips the expected X
  function automatic logic [8:0] ent(input int hold, input int ab, input bit bad_x, input bit chk_en);
    logic [3:0] h;
    logic [1:0] v;
    h = hold[3:0];
    v = ab[1:0];
    return {chk_en, v[0], v[1] ^ bad_x, v[0], v[1], h};
  endfunction

  exp_t q8[$];
  exp_t q16[$];
  int   busy_cnt8 = 0, busy_cnt16 = 0;
  logic done_d8 = 1'b0, done_d16 = 1'b0;

  // Monitors: one result popped per rising done
  always @(negedge clk) begin
    exp_t e;
    if (rst8) begin
      busy_cnt8 = 0;
      done_d8   = 1'b0;
    end else begin
      if (busy8) busy_cnt8++;
      if (done8 && !done_d8) begin
        $display("run8 done: pass=%0d errs=%0d step=%0d busy_cycles=%0d",
                 pass8, err_count8, err_step8, busy_cnt8);
        if (q8.size() == 0) chk("run8_unexpected", 1, 0);
        else begin
          e = q8.pop_front();
          chk("run8_pass", int'(pass8), int'(e.pass));
          chk("run8_err_count", int'(err_count8), e.cnt);
          chk("run8_err_step", int'(err_step8), e.step);
          chk("run8_len", busy_cnt8, e.len);
        end
        busy_cnt8 = 0;
      end
      done_d8 = done8;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst16) begin
      busy_cnt16 = 0;
      done_d16   = 1'b0;
    end else begin
      if (busy16) busy_cnt16++;
      if (done16 && !done_d16) begin
        $display("run16 done: pass=%0d errs=%0d step=%0d busy_cycles=%0d",
                 pass16, err_count16, err_step16, busy_cnt16);
        if (q16.size() == 0) chk("run16_unexpected", 1, 0);
        else begin
          e = q16.pop_front();
          chk("run16_pass", int'(pass16), int'(e.pass));
          chk("run16_err_count", int'(err_count16), e.cnt);
          chk("run16_err_step", int'(err_step16), e.step);
          chk("run16_len", busy_cnt16, e.len);
        end
        busy_cnt16 = 0;
      end
      done_d16 = done16;
    end
  end

  task automatic wr(input int sel, input int addr, input logic [8:0] d);
    @(posedge clk); #1;
    if (sel == 0) begin we8 = 1'b1; addr8 = addr[2:0]; data8 = d; end
    else begin we16 = 1'b1; addr16 = addr[3:0]; data16 = d; end
    @(posedge clk); #1;
    we8  = 1'b0;
    we16 = 1'b0;
  endtask

  // Returns one time unit after the edge that samples start
  task automatic pulse_start(input int sel);
    @(posedge clk); #1;
    if (sel == 0) start8 = 1'b1; else start16 = 1'b1;
    @(posedge clk); #1;
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int n;
    n = 0;
    while (!(sel == 0 ? done8 : done16) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic reset_dut(input int sel);
    @(posedge clk); #1;
    if (sel == 0) rst8 = 1'b1; else rst16 = 1'b1;
    @(posedge clk); #1;
    rst8  = 1'b0;
    rst16 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_tab[8];
    int seq[$];
    exp_t e;
    hold_tab = '{0, 1, 15, 2, 1, 0, 3, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_A", int'(A8), 0);
    chk("rst_B", int'(B8), 0);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_pass", int'(pass8), 0);
    chk("rst_err_count", int'(err_count8), 0);
    chk("rst_err_step", int'(err_step8), 0);
    rst8  = 1'b0;
    rst16 = 1'b0;

    // All-pass table, hold=2; a cfg write and a start pulse mid-run must both be ignored
    for (int i = 0; i < 8; i++) wr(0, i, ent(2, abv(i), 1'b0, 1'b1));
    e = '{pass: 1'b1, cnt: 0, step: 0, len: 16};
    q8.push_back(e);
    pulse_start(0);
    chk("first_busy", int'(busy8), 1);
    chk("first_A", int'(A8), 1);
    chk("first_B", int'(B8), 0);
    repeat (3) @(posedge clk);
    #1;
    we8 = 1'b1; addr8 = 3'd0; data8 = ent(2, abv(0), 1'b1, 1'b1); start8 = 1'b1;
    @(posedge clk); #1;
    we8 = 1'b0; start8 = 1'b0;
    wait_done(0);

    // Restart from DONE with the untouched table
    q8.push_back(e);
    pulse_start(0);
    wait_done(0);

`ifdef STIM_LOOP_EN
    // Hold start through the first wrap, release during the second pass
    e = '{pass: 1'b1, cnt: 0, step: 0, len: 32};
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      chk("loop_busy", int'(busy8), 1);
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    wait_done(0);
`endif

    // Reset in the middle of step 3, then a fresh run from step 0
    pulse_start(0);
    repeat (7) @(posedge clk);
    #1;
    chk("step3_busy", int'(busy8), 1);
    chk("step3_A", int'(A8), 0);
    chk("step3_B", int'(B8), 1);
    rst8 = 1'b1;
    #1;
    chk("midrst_A", int'(A8), 0);
    chk("midrst_B", int'(B8), 0);
    chk("midrst_busy", int'(busy8), 0);
    chk("midrst_done", int'(done8), 0);
    chk("midrst_err_count", int'(err_count8), 0);
    @(posedge clk); #1;
    rst8 = 1'b0;
    e = '{pass: 1'b1, cnt: 0, step: 0, len: 16};
    q8.push_back(e);
    pulse_start(0);
    chk("replay_A", int'(A8), 1);
    chk("replay_B", int'(B8), 0);
    wait_done(0);

    // Single mismatch at step 5
    reset_dut(0);
    wr(0, 5, ent(2, abv(5), 1'b1, 1'b1));
    e = '{pass: 1'b0, cnt: 1, step: 5, len: 16};
    q8.push_back(e);
    pulse_start(0);
    wait_done(0);

    // Hold edge cases: hold 0/1 last one cycle, hold 15 sampled once (step 2 mismatches)
    reset_dut(0);
    for (int i = 0; i < 8; i++) wr(0, i, ent(hold_tab[i], abv(i), (i == 2), 1'b1));
    seq.delete();
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < ((hold_tab[i] == 0) ? 1 : hold_tab[i]); c++) seq.push_back(abv(i));
    e = '{pass: 1'b0, cnt: 1, step: 2, len: 25};
    q8.push_back(e);
    pulse_start(0);
    for (int k = 0; k < seq.size(); k++) begin
      chk($sformatf("hold_ab_c%0d", k), int'({A8, B8}), seq[k]);
      @(posedge clk); #1;
    end
    wait_done(0);

    // Saturation on the 16-step instance, then check gating
    for (int i = 0; i < 16; i++) wr(1, i, ent(1, abv(i), 1'b1, 1'b1));
    e = '{pass: 1'b0, cnt: 15, step: 0, len: 16};
    q16.push_back(e);
    pulse_start(1);
    wait_done(1);
    reset_dut(1);
    for (int i = 0; i < 16; i++) wr(1, i, ent(1, abv(i), 1'b1, 1'b0));
    e = '{pass: 1'b1, cnt: 0, step: 0, len: 16};
    q16.push_back(e);
    pulse_start(1);
    wait_done(1);

    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
